// File: rtl/i2s_rx.sv
// I2S slave receiver: aligns to lrck word boundaries (one-bit data delay),
// assembles left/right words and hands complete frames over a valid/ack pair.
module i2s_rx #(
    parameter int WIDTH = 32
) (
    input  logic               sclk,
    input  logic               aclr,
    input  logic               lrck,
    input  logic               din,
    output logic [2*WIDTH-1:0] sample,
    output logic               sample_valid,
    input  logic               sample_ack,
    output logic               locked,
    output logic               overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t           state, state_next;
    logic             lrck_q, lrck_qq, din_q;
    logic [CW-1:0]    cnt, cnt_next, cnt_plus;
    logic [WIDTH-1:0] left_sr, right_sr;
    logic             take, shift_left, shift_right;
    logic             frame_pend, frame_next, locked_next;
    logic             edge_rise, edge_fall;

    assign edge_rise = lrck_q & ~lrck_qq;
    assign edge_fall = ~lrck_q & lrck_qq;

    // The bit seen on an edge cycle is the LSB of the word that is ending,
    // so it is captured before the counter restarts for the new word.
    assign take     = (state != SYNC) && (cnt != FULL);
    assign cnt_plus = take ? cnt + CW'(1) : cnt;

    always_ff @(posedge sclk) begin
        if (aclr) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shift_left  = 1'b0;
        shift_right = 1'b0;
        frame_next  = 1'b0;
        locked_next = locked;
        case (state)
            SYNC: begin
                locked_next = 1'b0;
                cnt_next    = '0;
                if (edge_fall) begin
                    state_next = LEFT;
                end
            end
            LEFT: begin
                shift_left = take;
                cnt_next   = cnt_plus;
                if (take && cnt_plus == FULL) begin
                    locked_next = 1'b1;
                end
                if (edge_rise) begin
                    cnt_next = '0;
                    if (cnt_plus == FULL) begin
                        state_next = RIGHT;
                    end else begin
                        state_next  = SYNC;
                        locked_next = 1'b0;
                    end
                end
            end
            RIGHT: begin
                shift_right = take;
                cnt_next    = cnt_plus;
                // RIGHT is only reachable after a complete left word
                if (take && cnt_plus == FULL) begin
                    frame_next = 1'b1;
                end
                if (edge_fall) begin
                    cnt_next = '0;
                    if (cnt_plus == FULL) begin
                        state_next = LEFT;
                    end else begin
                        state_next  = SYNC;
                        locked_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next  = SYNC;
                cnt_next    = '0;
                locked_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (aclr) begin
            lrck_q       <= 1'b0;
            lrck_qq      <= 1'b0;
            din_q        <= 1'b0;
            cnt          <= '0;
            left_sr      <= '0;
            right_sr     <= '0;
            frame_pend   <= 1'b0;
            locked       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            lrck_q     <= lrck;
            lrck_qq    <= lrck_q;
            din_q      <= din;
            cnt        <= cnt_next;
            frame_pend <= frame_next;
            locked     <= locked_next;
            if (shift_left) begin
                left_sr <= {left_sr[WIDTH-2:0], din_q};
            end
            if (shift_right) begin
                right_sr <= {right_sr[WIDTH-2:0], din_q};
            end
            if (frame_pend) begin
                sample       <= {left_sr, right_sr};
                sample_valid <= 1'b1;
                overrun      <= sample_valid & ~sample_ack;
            end else begin
                overrun <= 1'b0;
                if (sample_valid && sample_ack) begin
                    sample_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: builds a word-level I2S stream, predicts frames/lock from
// the word list, and compares the receiver outputs every bit clock.
module tb_i2s_rx;

    localparam int W = 32;

    logic            sclk = 1'b0;
    logic            aclr = 1'b1;
    logic            lrck = 1'b0;
    logic            din = 1'b0;
    logic            sample_ack = 1'b0;
    logic [2*W-1:0]  sample;
    logic            sample_valid;
    logic            locked;
    logic            overrun;

    i2s_rx #(.WIDTH(W)) dut (
        .sclk(sclk),
        .aclr(aclr),
        .lrck(lrck),
        .din(din),
        .sample(sample),
        .sample_valid(sample_valid),
        .sample_ack(sample_ack),
        .locked(locked),
        .overrun(overrun)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad = 0;

    // Stream as seen on the wire: one entry per word bit slot.
    logic seg_lr[$];
    logic seg_bit[$];
    logic seg_rst[$];
    int   seg_ackm[$];
    // Expected events keyed by the slot index whose posedge shows them.
    logic [2*W-1:0] load_evt[int];
    logic           lock_evt[int];

    int        prev_chan = 0;
    bit        left_ok = 1'b0;
    logic [W-1:0] cur_left = '0;
    int        ack_mode = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word-level reference: a left word is taken only when a falling lrck
    // edge starts it; a frame needs a complete left then a complete right.
    task automatic add_word(input bit chan, input logic [W-1:0] data, input int len, input int rst_at);
        int base;
        bit complete;
        base = seg_lr.size();
        for (int i = 0; i < len; i++) begin
            seg_lr.push_back(chan);
            seg_bit.push_back(i < W ? data[W-1-i] : 1'($urandom));
            seg_rst.push_back(i == rst_at);
            seg_ackm.push_back(ack_mode);
        end
        complete = (len >= W);
        if (rst_at >= 0) begin
            left_ok = 1'b0;
        end else if (!chan) begin
            if (prev_chan == 1) begin
                if (complete) begin
                    left_ok  = 1'b1;
                    cur_left = data;
                    lock_evt[base + W + 1] = 1'b1;
                end else begin
                    left_ok = 1'b0;
                    lock_evt[base + len + 1] = 1'b0;
                end
            end else begin
                left_ok = 1'b0;
            end
        end else begin
            if (left_ok) begin
                if (complete) load_evt[base + W + 2] = {cur_left, data};
                else lock_evt[base + len + 1] = 1'b0;
            end
            left_ok = 1'b0;
        end
        prev_chan = chan;
    endtask

    task automatic add_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int len);
        add_word(1'b0, l, len, -1);
        add_word(1'b1, r, len, -1);
    endtask

    initial begin
        logic           v, ov, lk, ack, load;
        logic [2*W-1:0] s;
        string          tag;

        // Reset held with lrck low; outputs must be cleared.
        repeat (2) @(posedge sclk);
        #1;
        check("reset_sample", 64'(sample), 64'd0);
        check("reset_valid", 64'(sample_valid), 64'd0);
        check("reset_locked", 64'(locked), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);

        // Stream begins low: first frame has no falling edge and is dropped.
        ack_mode = 0;
        add_word(1'b0, '0, 4, 0);
        add_frame(32'hA5A5_0001, 32'h5A5A_0002, W);
        add_frame(32'hA5A5_0001, 32'h5A5A_0002, W);
        // Unacknowledged frame replaced by the next one.
        add_frame(32'h1111_1111, 32'h2222_2222, W);
        ack_mode = 1;
        repeat (3) add_frame($urandom, $urandom, W);
        // Truncated left word, orphan right, then a good frame.
        ack_mode = 3;
        add_word(1'b0, $urandom, 20, -1);
        add_word(1'b1, $urandom, W, -1);
        add_frame($urandom, $urandom, W);
        // Over-long words: trailing bits ignored.
        ack_mode = 0;
        add_frame(32'hDEAD_BEEF, 32'hDEAD_BEEF, 34);
        add_frame(32'hDEAD_BEEF, 32'hDEAD_BEEF, 34);
        // Ack coincides with every load.
        ack_mode = 2;
        add_frame($urandom, $urandom, W);
        add_frame($urandom, $urandom, W);
        // Reset in the middle of a right word, then recovery.
        ack_mode = 1;
        add_word(1'b0, $urandom, W, -1);
        add_word(1'b1, $urandom, W, 16);
        add_frame($urandom, $urandom, W);
        add_frame($urandom, $urandom, W);
        add_word(1'b0, $urandom, 8, -1);

        v = 1'b0; ov = 1'b0; lk = 1'b0; s = '0;
        for (int i = 0; i < seg_lr.size(); i++) begin
            @(negedge sclk);
            lrck = seg_lr[i];
            din  = (i == 0) ? 1'b0 : seg_bit[i-1];
            aclr = seg_rst[i];
            load = load_evt.exists(i);
            case (seg_ackm[i])
                0: ack = 1'b0;
                1: ack = ($urandom_range(0, 3) == 0);
                2: ack = load;
                default: ack = 1'b1;
            endcase
            sample_ack = ack;
            @(posedge sclk);
            #1;
            if (seg_rst[i]) begin
                v = 1'b0; ov = 1'b0; lk = 1'b0; s = '0;
            end else begin
                ov = load && v && !ack;
                if (load) begin
                    s = load_evt[i];
                    v = 1'b1;
                end else if (ack && v) begin
                    v = 1'b0;
                end
                if (lock_evt.exists(i)) lk = lock_evt[i];
            end
            tag = $sformatf("slot%0d", i);
            check({tag, "_valid"}, 64'(sample_valid), 64'(v));
            check({tag, "_overrun"}, 64'(overrun), 64'(ov));
            check({tag, "_locked"}, 64'(locked), 64'(lk));
            check({tag, "_sample"}, 64'(sample), 64'(s));
        end
        sample_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
